// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared encodings for the pipeline hazard controller: ALUOp codes
//           that occupy EX for several cycles, Jump encodings and FSM states.
// Revision: 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // ALUOp codes that start a multi-cycle EX operation
  localparam logic [3:0] ALUOP_MULT = 4'b1100;
  localparam logic [3:0] ALUOP_DIV  = 4'b1101;

  // Jump field carried in ID/EX; anything other than JUMP_NONE redirects
  localparam logic [1:0] JUMP_NONE  = 2'b00;
  localparam logic [1:0] JUMP_J     = 2'b01;
  localparam logic [1:0] JUMP_JR    = 2'b10;
  localparam logic [1:0] JUMP_JAL   = 2'b11;

  // Controller state, explicitly one bit wide
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Larger of two integers, used to size the occupancy counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next value: advance on inc unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Stall/flush controller for the five-stage pipeline. Resolves
//           control-transfer redirects, load-use hazards and multi-cycle
//           MULT/DIV occupancy of EX, and keeps saturating statistics.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [3:0]       ex_alu_op,
  input  logic [1:0]       ex_jump,
  input  logic             ex_j_jump,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_bubble,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // Occupancy counter holds at most LAT-2; never narrower than one bit
  localparam int MAX_LAT  = max_int(MUL_LAT, DIV_LAT);
  localparam int CNT_BITS = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);
  localparam logic [CNT_BITS-1:0] MUL_LOAD = CNT_BITS'(MUL_LAT - 2);
  localparam logic [CNT_BITS-1:0] DIV_LOAD = CNT_BITS'(DIV_LAT - 2);

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic is_run;
  logic redirect;
  logic md_start;
  logic load_use;
  logic busy_stall;
  logic md_release;
  logic rd_match;

  // Hazard decode; priority in RUN is redirect > MULT/DIV > load-use
  always_comb begin
    is_run     = (state_q == RUN);
    redirect   = is_run && ((ex_jump != JUMP_NONE) || ex_j_jump || ex_branch_taken);
    md_start   = is_run && !redirect &&
                 ((ex_alu_op == ALUOP_MULT) || (ex_alu_op == ALUOP_DIV));
    rd_match   = (ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt));
    load_use   = is_run && !redirect && !md_start &&
                 ex_mem_read && (ex_rd != 5'd0) && rd_match;
    busy_stall = (state_q == BUSY) && (cnt_q != '0);
    md_release = (state_q == BUSY) && (cnt_q == '0);
  end

  // Pipeline register controls; reset forces a fully frozen, bubbled pipe
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    muldiv_done  = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_bubble = 1'b1;
    end else if (redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (md_start || busy_stall) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (md_release) begin
      muldiv_done = 1'b1;
    end
  end

  // FSM next state: load LAT-2 on start, count down, release at zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = (ex_alu_op == ALUOP_DIV) ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State and occupancy registers; reset aborts any MULT/DIV in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_write),
    .count (stall_cycles)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect),
    .count (flush_events)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Self-checking bench for pipe_hazard_ctrl. Each cycle's expected
//           controls and statistics are queued when stimulus is driven and
//           compared on the following falling edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, muldiv_done}
  localparam logic [6:0] E_DEF = 7'b1101000;
  localparam logic [6:0] E_RED = 7'b1111100;
  localparam logic [6:0] E_LU  = 7'b0001100;
  localparam logic [6:0] E_MD  = 7'b0000010;
  localparam logic [6:0] E_REL = 7'b1101001;
  localparam logic [6:0] E_RST = 7'b0010110;

  localparam logic [3:0] OP_MULT = 4'b1100;
  localparam logic [3:0] OP_DIV  = 4'b1101;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs, id_rt, ex_rd;
  logic             id_uses_rt, ex_mem_read, ex_j_jump, ex_branch_taken;
  logic [3:0]       ex_alu_op;
  logic [1:0]       ex_jump;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic             exmem_bubble, muldiv_done;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  typedef struct {
    string      tag;
    logic [6:0] ctrl;
    int         stalls;
    int         flushes;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;
  int   m_stall;
  int   m_flush;

  pipe_hazard_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_alu_op       (ex_alu_op),
    .ex_jump         (ex_jump),
    .ex_j_jump       (ex_j_jump),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_write      (idex_write),
    .idex_flush      (idex_flush),
    .exmem_bubble    (exmem_bubble),
    .muldiv_done     (muldiv_done),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive, queue the expectation, compare at negedge
  task automatic step(input string tag, input logic rst, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic mr,
                      input logic [4:0] rd, input logic [3:0] aop,
                      input logic [1:0] jmp, input logic jj, input logic bt,
                      input logic [6:0] ectrl);
    exp_t e;
    exp_t got;
    rst_n           = rst;
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rt      = urt;
    ex_mem_read     = mr;
    ex_rd           = rd;
    ex_alu_op       = aop;
    ex_jump         = jmp;
    ex_j_jump       = jj;
    ex_branch_taken = bt;
    if (!rst) begin
      m_stall = 0;
      m_flush = 0;
    end
    e.tag     = tag;
    e.ctrl    = ectrl;
    e.stalls  = m_stall;
    e.flushes = m_flush;
    exp_q.push_back(e);
    if (rst) begin
      if (!ectrl[6] && m_stall < CMAX) m_stall++;
      if (ectrl == E_RED && m_flush < CMAX) m_flush++;
    end
    @(negedge clk);
    got = exp_q.pop_front();
    chk({got.tag, ".ctrl"},
        {25'd0, pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, muldiv_done},
        {25'd0, got.ctrl});
    chk({got.tag, ".stall_cycles"}, {{(32-CNT_W){1'b0}}, stall_cycles}, got.stalls);
    chk({got.tag, ".flush_events"}, {{(32-CNT_W){1'b0}}, flush_events}, got.flushes);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [6:0] ectrl);
    step(tag, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 4'd0, 2'b00, 1'b0, 1'b0, ectrl);
  endtask

  task automatic md(input string tag, input logic [3:0] op, input logic [6:0] ectrl);
    step(tag, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd9, op, 2'b00, 1'b0, 1'b0, ectrl);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_stall = 0;
    m_flush = 0;

    step("reset", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 2'b00, 1'b0, 1'b0, E_RST);
    idle("first_run", E_DEF);

    step("lu_rs", 1'b1, 5'd5, 5'd6, 1'b0, 1'b1, 5'd5, 4'd0, 2'b00, 1'b0, 1'b0, E_LU);
    idle("after_lu", E_DEF);
    step("lu_rd0", 1'b1, 5'd0, 5'd6, 1'b0, 1'b1, 5'd0, 4'd0, 2'b00, 1'b0, 1'b0, E_DEF);
    step("lu_rt", 1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 4'd0, 2'b00, 1'b0, 1'b0, E_LU);
    step("lu_rt_unused", 1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 4'd0, 2'b00, 1'b0, 1'b0, E_DEF);
    step("no_load", 1'b1, 5'd5, 5'd6, 1'b0, 1'b0, 5'd5, 4'd0, 2'b00, 1'b0, 1'b0, E_DEF);

    step("redir_jump", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 4'd0, 2'b01, 1'b0, 1'b0, E_RED);
    step("redir_jjump", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 4'd0, 2'b00, 1'b1, 1'b0, E_RED);
    step("redir_over_lu", 1'b1, 5'd5, 5'd6, 1'b0, 1'b1, 5'd5, 4'd0, 2'b00, 1'b0, 1'b1, E_RED);
    idle("after_redir", E_DEF);

    for (int i = 0; i < MUL_LAT - 1; i++) md("mult_stall", OP_MULT, E_MD);
    md("mult_release", OP_MULT, E_REL);
    idle("after_mult", E_DEF);

    for (int i = 0; i < DIV_LAT - 1; i++) md("div_stall", OP_DIV, E_MD);
    md("div_release", OP_DIV, E_REL);
    for (int i = 0; i < MUL_LAT - 1; i++) md("b2b_mult_stall", OP_MULT, E_MD);
    md("b2b_mult_release", OP_MULT, E_REL);
    idle("after_b2b", E_DEF);

    for (int i = 0; i < MUL_LAT - 1; i++) md("sat_mult_stall", OP_MULT, E_MD);
    md("sat_mult_release", OP_MULT, E_REL);
    idle("after_sat", E_DEF);

    md("rdiv_stall1", OP_DIV, E_MD);
    md("rdiv_stall2", OP_DIV, E_MD);
    step("rdiv_reset", 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd9, OP_DIV, 2'b00, 1'b0, 1'b0, E_RST);
    step("rdiv_reset_hold", 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd9, OP_DIV, 2'b00, 1'b0, 1'b0, E_RST);
    for (int i = 0; i < DIV_LAT; i++) idle("post_reset_idle", E_DEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
